// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request, response and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if;
  logic        req_valid0, req_ready0, req_read0, req_write0;
  logic [63:0] req_addr0, req_wdata0;
  logic        req_valid1, req_ready1, req_read1, req_write1;
  logic [63:0] req_addr1, req_wdata1;
  logic        resp_valid0, resp_err0;
  logic [63:0] resp_rdata0;
  logic        resp_valid1, resp_err1;
  logic [63:0] resp_rdata1;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  modport slave (
    input  req_valid0, req_read0, req_write0, req_addr0, req_wdata0,
    input  req_valid1, req_read1, req_write1, req_addr1, req_wdata1,
    output req_ready0, req_ready1,
    output resp_valid0, resp_err0, resp_rdata0,
    output resp_valid1, resp_err1, resp_rdata1,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid0, req_read0, req_write0, req_addr0, req_wdata0,
    output req_valid1, req_read1, req_write1, req_addr1, req_wdata1,
    input  req_ready0, req_ready1,
    input  resp_valid0, resp_err0, resp_rdata0,
    input  resp_valid1, resp_err1, resp_rdata1,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between the pipeline (port 0) and loader (port 1)
module dmem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_BYTES    = 1024
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [63:0]   ADDR_MAX   = 64'(MEM_BYTES - 8);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [LW-1:0] WAIT_INIT  = LW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] starve_cnt;
  logic [LW-1:0] wait_cnt;
  logic          port_q, err_q;
  logic          mem_read_q, mem_write_q;
  logic [63:0]   mem_addr_q, mem_wdata_q, rdata0_q, rdata1_q;

  logic          grant1, accept, ready0, ready1, resp_v0, resp_v1;
  logic          sel_read, sel_write, sel_legal;
  logic [63:0]   sel_addr, sel_wdata;

  // Port 1 wins when port 0 is idle or has been served STARVE_LIMIT times in a row.
  assign grant1    = bus.req_valid1 && (!bus.req_valid0 || starve_cnt == STARVE_MAX);
  assign sel_read  = grant1 ? bus.req_read1  : bus.req_read0;
  assign sel_write = grant1 ? bus.req_write1 : bus.req_write0;
  assign sel_addr  = grant1 ? bus.req_addr1  : bus.req_addr0;
  assign sel_wdata = grant1 ? bus.req_wdata1 : bus.req_wdata0;
  assign sel_legal = (sel_read != sel_write) && (sel_addr[2:0] == 3'b000) && (sel_addr <= ADDR_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    case (state)
      IDLE: begin
        ready1 = !reset && grant1;
        ready0 = !reset && !grant1 && bus.req_valid0;
        if (ready0 || ready1) state_nxt = sel_legal ? BUSY : RESP;
      end
      BUSY:    if (wait_cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = ready0 || ready1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      port_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          port_q <= ready1;
          err_q  <= !sel_legal;
          if (ready0 && bus.req_valid1) begin
            if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + CW'(1);
          end else begin
            starve_cnt <= '0;
          end
          // Rejected requests never reach the memory bus; they only zero the response data.
          if (sel_legal) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_read_q  <= sel_read;
            mem_write_q <= sel_write;
            wait_cnt    <= WAIT_INIT;
          end else if (ready1) begin
            rdata1_q <= '0;
          end else begin
            rdata0_q <= '0;
          end
        end
        BUSY: begin
          mem_write_q <= 1'b0;
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - LW'(1);
          end else begin
            mem_read_q <= 1'b0;
            if (port_q) rdata1_q <= mem_read_q ? bus.mem_rdata : '0;
            else        rdata0_q <= mem_read_q ? bus.mem_rdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_v0 = (state == RESP) && !port_q;
  assign resp_v1 = (state == RESP) && port_q;

  assign bus.req_ready0  = ready0;
  assign bus.req_ready1  = ready1;
  assign bus.resp_valid0 = resp_v0;
  assign bus.resp_valid1 = resp_v1;
  assign bus.resp_err0   = resp_v0 && err_q;
  assign bus.resp_err1   = resp_v1 && err_q;
  assign bus.resp_rdata0 = rdata0_q;
  assign bus.resp_rdata1 = rdata1_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters.
- Port 0 is the pipeline memory-access stage; port 1 is the program loader/debug port.
- Fixed priority to port 0, with an anti-starvation counter for port 1.
- Issues one access at a time with a parameterised memory latency, returns a registered response, and rejects illegal or out-of-range requests without touching memory.

Parameters:
- MEM_LATENCY, 1, cycles mem_read/mem_write are driven before mem_rdata is sampled (>=1).
- STARVE_LIMIT, 4, consecutive port-0 grants while port 1 waits before port 1 is forced.
- MEM_BYTES, 1024, legal address range is 0 to MEM_BYTES-8 inclusive, 8-byte aligned.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid0 / req_valid1  input  1  request present on port 0 / port 1.
- req_ready0 / req_ready1  output  1  request accepted this cycle (combinational).
- req_read0 / req_read1  input  1  load request.
- req_write0 / req_write1  input  1  store request.
- req_addr0 / req_addr1  input  64  byte address.
- req_wdata0 / req_wdata1  input  64  store data.
- resp_valid0 / resp_valid1  output  1  one-cycle response pulse.
- resp_rdata0 / resp_rdata1  output  64  load data, valid with resp_valid.
- resp_err0 / resp_err1  output  1  request rejected, valid with resp_valid.
- mem_read  output  1  to data_memory.
- mem_write  output  1  to data_memory.
- mem_addr  output  64  to data_memory.
- mem_wdata  output  64  to data_memory.
- mem_rdata  input  64  from data_memory.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, starve_cnt=0, wait_cnt=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - All resp_valid/resp_err/resp_rdata=0; req_ready both 0 while reset high.
- Reset mid-access aborts the access: no response is ever issued for it.
- States: IDLE, BUSY, RESP.
- IDLE grant selection (combinational):
  - Port 1 is chosen if req_valid1 and (!req_valid0 or starve_cnt==STARVE_LIMIT).
  - Otherwise port 0 is chosen if req_valid0.
  - req_ready of the chosen port is 1; the other port's ready is 0.
  - req_ready is 0 in BUSY and RESP.
- Accept (valid&&ready): latch port id, read/write, addr, wdata.
- Legality check at accept. A request is illegal if any of:
  - read==write (both set or neither set).
  - addr[2:0]!=0.
  - addr>MEM_BYTES-8.
- Illegal request: go directly to RESP with err=1, rdata=0. mem_* is not driven.
- Legal request: go to BUSY with wait_cnt=MEM_LATENCY-1.
  - mem_addr and mem_wdata are registered from the accept.
  - mem_read=read for every BUSY cycle.
  - mem_write=write for the first BUSY cycle only.
- BUSY:
  - While wait_cnt!=0, decrement it.
  - When wait_cnt==0: capture mem_rdata into the response register if read (0 if write), drop mem_read/mem_write, go to RESP.
- RESP (one cycle): resp_valid of the latched port =1 and resp_err as latched. Then go to IDLE.
- Latency: legal request accepted in cycle T gives resp_valid at T+MEM_LATENCY+1. Illegal request gives resp_valid at T+1.
- Throughput: one legal access per MEM_LATENCY+2 cycles; the next accept is possible in the cycle after RESP.
- starve_cnt update, at accept only:
  - Port-0 accept while req_valid1=1: increment, saturating at STARVE_LIMIT.
  - Port-1 accept: clear to 0.
  - Port-0 accept with req_valid1=0: clear to 0.
- Requesters must hold valid and payload stable until ready; payload changes while not ready are ignored.
- resp_rdata0/1 hold their last value between responses. resp_err is 0 whenever resp_valid is 0.

Test Plan:
- Port-0 load, MEM_LATENCY=1, with 0x5A at address 0x10 preloaded:
  - Port 0 requests read addr 0x10.
  - Required: ready0 in cycle T, mem_read high in T+1 only, resp_valid0 with rdata 0x5A at T+2.
- Port-1 store then port-0 load:
  - Port 1 stores 0x1234 at 0x20; port 0 then loads 0x20.
  - Required: mem_write is a single-cycle pulse, and resp_rdata0=0x1234.
- Both ports valid continuously, STARVE_LIMIT=4:
  - Required: grant order 0,0,0,0,1,0,0,0,0,1; starve_cnt returns to 0 after each port-1 grant.
- Illegal requests:
  - Addresses 0x13 and MEM_BYTES.
  - Request with read=write=1.
  - Required for each: resp_err=1 one cycle after accept, with mem_read and mem_write never asserted.
- MEM_LATENCY=3, load 0x40:
  - Required: mem_read high for exactly 3 cycles, resp_valid at T+4, and req_ready0/1=0 throughout.
- Reset mid-access:
  - Assert reset during the second BUSY cycle of a MEM_LATENCY=3 load.
  - Required: mem_read drops immediately, no resp_valid, and a new request is accepted the first cycle after reset releases.
